// File: rtl/baw_pkg.sv
// Shared constants and result encodings for the black-and-white card game.
package baw_pkg;

  localparam int unsigned NUM_CARDS = 9;
  localparam int unsigned IDX_W     = 4;

  localparam logic [IDX_W-1:0] NO_CARD = 4'hF;

  typedef enum logic [1:0] {
    RES_DRAW = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_NONE = 2'b11
  } res_e;

endpackage

// File: rtl/baw_hand.sv
// One player's hand: play edge detect, validity check, hand mask, last card and colour counts.
// Build option BAW_ONEHOT_CHECK_EN rejects card selections that are not exactly one-hot.
module baw_hand #(
  parameter int unsigned NUM_CARDS = 9
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr_i,
  input  logic [NUM_CARDS-1:0] card_sel_i,
  input  logic                 play_i,
  output logic [NUM_CARDS-1:0] hand_o,
  output logic [3:0]           card_o,
  output logic                 card_black_o,
  output logic [3:0]           black_o,
  output logic [3:0]           white_o,
  output logic                 reject_o
);
  import baw_pkg::*;

  logic                 play_prev_q, play_prev_d;
  logic [NUM_CARDS-1:0] hand_q, hand_d;
  logic [IDX_W-1:0]     card_q, card_d;
  logic                 card_black_q, card_black_d;
  logic                 reject_q, reject_d;

  logic [IDX_W-1:0]     sel_idx_c;
  logic                 sel_ok_c;
  logic                 rise_c;
  logic                 valid_c;
  logic [3:0]           black_c, white_c;

  // Lowest set bit wins when several cards are selected.
  always_comb begin
    sel_idx_c = '0;
    for (int i = int'(NUM_CARDS) - 1; i >= 0; i--) begin
      if (card_sel_i[i]) sel_idx_c = IDX_W'(i);
    end
  end

`ifdef BAW_ONEHOT_CHECK_EN
  assign sel_ok_c = $onehot(card_sel_i);
`else
  assign sel_ok_c = |card_sel_i;
`endif

  assign rise_c  = play_i & ~play_prev_q;
  assign valid_c = sel_ok_c & hand_q[sel_idx_c];

  always_comb begin
    play_prev_d  = play_i;
    hand_d       = hand_q;
    card_d       = card_q;
    card_black_d = card_black_q;
    reject_d     = 1'b0;
    if (clr_i) begin
      hand_d       = {NUM_CARDS{1'b1}};
      card_d       = NO_CARD;
      card_black_d = 1'b0;
    end else if (rise_c) begin
      if (valid_c) begin
        hand_d[sel_idx_c] = 1'b0;
        card_d            = sel_idx_c;
        card_black_d      = sel_idx_c[0];
      end else begin
        reject_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      play_prev_q  <= 1'b0;
      hand_q       <= {NUM_CARDS{1'b1}};
      card_q       <= NO_CARD;
      card_black_q <= 1'b0;
      reject_q     <= 1'b0;
    end else begin
      play_prev_q  <= play_prev_d;
      hand_q       <= hand_d;
      card_q       <= card_d;
      card_black_q <= card_black_d;
      reject_q     <= reject_d;
    end
  end

  // Odd positions are black cards, even positions white.
  always_comb begin
    black_c = '0;
    white_c = '0;
    for (int unsigned i = 0; i < NUM_CARDS; i++) begin
      if ((i % 2) != 0) black_c = black_c + 4'(hand_q[i]);
      else              white_c = white_c + 4'(hand_q[i]);
    end
  end

  assign hand_o       = hand_q;
  assign card_o       = card_q;
  assign card_black_o = card_black_q;
  assign reject_o     = reject_q;
  assign black_o      = black_c;
  assign white_o      = white_c;

endmodule

// File: rtl/black_and_white.sv
// Two-player black-and-white card game: two hand instances plus the round comparator.
// Build option BAW_ONEHOT_CHECK_EN is honoured inside baw_hand.
module black_and_white #(
  parameter int unsigned NUM_CARDS = 9
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clr_i,
  input  logic [NUM_CARDS-1:0] card_sel_i,
  input  logic                 play_p1_i,
  input  logic                 play_p2_i,
  output logic [NUM_CARDS-1:0] p1_hand_o,
  output logic [NUM_CARDS-1:0] p2_hand_o,
  output logic [3:0]           p1_card_o,
  output logic [3:0]           p2_card_o,
  output logic [3:0]           p1_black_o,
  output logic [3:0]           p1_white_o,
  output logic [3:0]           p2_black_o,
  output logic [3:0]           p2_white_o,
  output logic                 p1_card_black_o,
  output logic                 p2_card_black_o,
  output logic [1:0]           match_o,
  output logic [1:0]           reject_o
);
  import baw_pkg::*;

  logic p1_reject, p2_reject;
  res_e res_c;

  baw_hand #(.NUM_CARDS(NUM_CARDS)) u_p1 (
    .clk          (clk),
    .resetn       (resetn),
    .clr_i        (clr_i),
    .card_sel_i   (card_sel_i),
    .play_i       (play_p1_i),
    .hand_o       (p1_hand_o),
    .card_o       (p1_card_o),
    .card_black_o (p1_card_black_o),
    .black_o      (p1_black_o),
    .white_o      (p1_white_o),
    .reject_o     (p1_reject)
  );

  baw_hand #(.NUM_CARDS(NUM_CARDS)) u_p2 (
    .clk          (clk),
    .resetn       (resetn),
    .clr_i        (clr_i),
    .card_sel_i   (card_sel_i),
    .play_i       (play_p2_i),
    .hand_o       (p2_hand_o),
    .card_o       (p2_card_o),
    .card_black_o (p2_card_black_o),
    .black_o      (p2_black_o),
    .white_o      (p2_white_o),
    .reject_o     (p2_reject)
  );

  // A round is only decided once both players have a card on the table.
  always_comb begin
    res_c = RES_NONE;
    if ((p1_card_o != NO_CARD) && (p2_card_o != NO_CARD)) begin
      if (p1_card_o > p2_card_o)      res_c = RES_P1;
      else if (p1_card_o < p2_card_o) res_c = RES_P2;
      else                            res_c = RES_DRAW;
    end
  end

  assign match_o  = 2'(res_c);
  assign reject_o = {p2_reject, p1_reject};

endmodule

// File: tb/tb_black_and_white.sv
// Directed, table-driven bench for black_and_white; expected values are hand-computed.
module tb_black_and_white;

  logic       clk;
  logic       resetn;
  logic       clr_i;
  logic [8:0] card_sel_i;
  logic       play_p1_i, play_p2_i;
  logic [8:0] p1_hand_o, p2_hand_o;
  logic [3:0] p1_card_o, p2_card_o;
  logic [3:0] p1_black_o, p1_white_o, p2_black_o, p2_white_o;
  logic       p1_card_black_o, p2_card_black_o;
  logic [1:0] match_o, reject_o;

  int n_checks = 0;
  int n_fail   = 0;

  black_and_white #(.NUM_CARDS(9)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .clr_i           (clr_i),
    .card_sel_i      (card_sel_i),
    .play_p1_i       (play_p1_i),
    .play_p2_i       (play_p2_i),
    .p1_hand_o       (p1_hand_o),
    .p2_hand_o       (p2_hand_o),
    .p1_card_o       (p1_card_o),
    .p2_card_o       (p2_card_o),
    .p1_black_o      (p1_black_o),
    .p1_white_o      (p1_white_o),
    .p2_black_o      (p2_black_o),
    .p2_white_o      (p2_white_o),
    .p1_card_black_o (p1_card_black_o),
    .p2_card_black_o (p2_card_black_o),
    .match_o         (match_o),
    .reject_o        (reject_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       clr;
    logic [8:0] sel;
    logic       p1, p2;
    logic [8:0] h1, h2;
    logic [3:0] c1, c2;
    logic       cb1, cb2;
    logic [3:0] b1, w1, b2, w2;
    logic [1:0] m, rej;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    chk({tag, " p1_hand"},  32'(p1_hand_o),       32'(v.h1));
    chk({tag, " p2_hand"},  32'(p2_hand_o),       32'(v.h2));
    chk({tag, " p1_card"},  32'(p1_card_o),       32'(v.c1));
    chk({tag, " p2_card"},  32'(p2_card_o),       32'(v.c2));
    chk({tag, " p1_cblk"},  32'(p1_card_black_o), 32'(v.cb1));
    chk({tag, " p2_cblk"},  32'(p2_card_black_o), 32'(v.cb2));
    chk({tag, " p1_black"}, 32'(p1_black_o),      32'(v.b1));
    chk({tag, " p1_white"}, 32'(p1_white_o),      32'(v.w1));
    chk({tag, " p2_black"}, 32'(p2_black_o),      32'(v.b2));
    chk({tag, " p2_white"}, 32'(p2_white_o),      32'(v.w2));
    chk({tag, " match"},    32'(match_o),         32'(v.m));
    chk({tag, " reject"},   32'(reject_o),        32'(v.rej));
  endtask

  task automatic apply_row(input int idx);
    vec_t v;
    v = vecs[idx];
    clr_i      = v.clr;
    card_sel_i = v.sel;
    play_p1_i  = v.p1;
    play_p2_i  = v.p2;
    step();
    check_vec($sformatf("row%0d", idx), v);
  endtask

`ifdef BAW_ONEHOT_CHECK_EN
  localparam logic [8:0] H1X  = 9'h177;
  localparam logic [3:0] C1X  = 4'd3;
  localparam logic       CB1X = 1'b1;
  localparam logic [3:0] W1X  = 4'd5;
  localparam logic [1:0] MX   = 2'b00;
  localparam logic [1:0] R6   = 2'b01;
`else
  localparam logic [8:0] H1X  = 9'h176;
  localparam logic [3:0] C1X  = 4'd0;
  localparam logic       CB1X = 1'b0;
  localparam logic [3:0] W1X  = 4'd4;
  localparam logic [1:0] MX   = 2'b10;
  localparam logic [1:0] R6   = 2'b00;
`endif

  initial begin
    // clr sel    p1 p2 h1      h2      c1    c2    cb1 cb2 b1 w1 b2 w2 m      rej
    vecs.push_back('{0, 9'h000, 0, 0, 9'h1FF, 9'h1FF, 4'hF, 4'hF, 0, 0, 4, 5, 4, 5, 2'b11, 2'b00});
    vecs.push_back('{0, 9'h010, 0, 1, 9'h17F, 9'h1EF, 4'h7, 4'h4, 1, 0, 3, 5, 4, 4, 2'b01, 2'b00});
    vecs.push_back('{0, 9'h080, 1, 0, 9'h17F, 9'h1EF, 4'h7, 4'h4, 1, 0, 3, 5, 4, 4, 2'b01, 2'b01});
    vecs.push_back('{0, 9'h080, 0, 0, 9'h17F, 9'h1EF, 4'h7, 4'h4, 1, 0, 3, 5, 4, 4, 2'b01, 2'b00});
    vecs.push_back('{0, 9'h008, 1, 1, 9'h177, 9'h1E7, 4'h3, 4'h3, 1, 1, 2, 5, 3, 4, 2'b00, 2'b00});
    vecs.push_back('{0, 9'h000, 0, 0, 9'h177, 9'h1E7, 4'h3, 4'h3, 1, 1, 2, 5, 3, 4, 2'b00, 2'b00});
    vecs.push_back('{0, 9'h005, 1, 0, H1X,    9'h1E7, C1X,  4'h3, CB1X, 1, 2, W1X, 3, 4, MX, R6});
    vecs.push_back('{0, 9'h005, 0, 0, H1X,    9'h1E7, C1X,  4'h3, CB1X, 1, 2, W1X, 3, 4, MX, 2'b00});
    vecs.push_back('{0, 9'h000, 0, 1, H1X,    9'h1E7, C1X,  4'h3, CB1X, 1, 2, W1X, 3, 4, MX, 2'b10});
    vecs.push_back('{0, 9'h000, 0, 0, H1X,    9'h1E7, C1X,  4'h3, CB1X, 1, 2, W1X, 3, 4, MX, 2'b00});
    vecs.push_back('{1, 9'h002, 1, 0, 9'h1FF, 9'h1FF, 4'hF, 4'hF, 0, 0, 4, 5, 4, 5, 2'b11, 2'b00});
    vecs.push_back('{0, 9'h002, 1, 0, 9'h1FF, 9'h1FF, 4'hF, 4'hF, 0, 0, 4, 5, 4, 5, 2'b11, 2'b00});
    vecs.push_back('{0, 9'h002, 0, 0, 9'h1FF, 9'h1FF, 4'hF, 4'hF, 0, 0, 4, 5, 4, 5, 2'b11, 2'b00});

    resetn     = 1'b0;
    clr_i      = 1'b0;
    card_sel_i = '0;
    play_p1_i  = 1'b0;
    play_p2_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst p1_hand", 32'(p1_hand_o), 32'h1FF);
    chk("rst p1_card", 32'(p1_card_o), 32'hF);
    chk("rst reject",  32'(reject_o),  32'h0);
    resetn = 1'b1;

    apply_row(0);

    // Held play level commits exactly once.
    card_sel_i = 9'h080;
    play_p1_i  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("hold%0d p1_hand", c),  32'(p1_hand_o),       32'h17F);
      chk($sformatf("hold%0d p1_card", c),  32'(p1_card_o),       32'h7);
      chk($sformatf("hold%0d p1_cblk", c),  32'(p1_card_black_o), 32'h1);
      chk($sformatf("hold%0d p1_black", c), 32'(p1_black_o),      32'h3);
      chk($sformatf("hold%0d match", c),    32'(match_o),         32'h3);
      chk($sformatf("hold%0d reject", c),   32'(reject_o),        32'h0);
    end

    for (int r = 1; r < vecs.size(); r++) apply_row(r);

    // Fresh play after clear commits card 1.
    card_sel_i = 9'h002;
    play_p1_i  = 1'b1;
    step();
    chk("play1 p1_hand", 32'(p1_hand_o),       32'h1FD);
    chk("play1 p1_card", 32'(p1_card_o),       32'h1);
    chk("play1 p1_cblk", 32'(p1_card_black_o), 32'h1);
    chk("play1 p1_black", 32'(p1_black_o),     32'h3);

    // Asynchronous reset between clock edges.
    #2 resetn = 1'b0;
    #1;
    chk("arst p1_hand", 32'(p1_hand_o),       32'h1FF);
    chk("arst p1_card", 32'(p1_card_o),       32'hF);
    chk("arst p1_cblk", 32'(p1_card_black_o), 32'h0);
    chk("arst match",   32'(match_o),         32'h3);

    // Play level already high at reset release counts as an edge.
    play_p1_i  = 1'b0;
    play_p2_i  = 1'b1;
    card_sel_i = 9'h001;
    step();
    chk("inrst p2_hand", 32'(p2_hand_o), 32'h1FF);
    resetn = 1'b1;
    step();
    chk("rel p2_hand",  32'(p2_hand_o),  32'h1FE);
    chk("rel p2_card",  32'(p2_card_o),  32'h0);
    chk("rel p2_white", 32'(p2_white_o), 32'h4);
    chk("rel match",    32'(match_o),    32'h3);
    chk("rel reject",   32'(reject_o),   32'h0);
    play_p2_i = 1'b0;

    // Empty the P1 hand, then any further play is rejected.
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      card_sel_i = 9'(1 << i);
      play_p1_i  = 1'b1;
      step();
      chk($sformatf("empty%0d reject", i), 32'(reject_o), 32'h0);
      play_p1_i = 1'b0;
      step();
    end
    chk("empty p1_hand",  32'(p1_hand_o),  32'h000);
    chk("empty p1_black", 32'(p1_black_o), 32'h0);
    chk("empty p1_white", 32'(p1_white_o), 32'h0);
    chk("empty p1_card",  32'(p1_card_o),  32'h8);
    card_sel_i = 9'h001;
    play_p1_i  = 1'b1;
    step();
    chk("empty reject",  32'(reject_o),  32'h1);
    chk("empty p1_card2", 32'(p1_card_o), 32'h8);
    play_p1_i = 1'b0;
    step();
    chk("empty reject_off", 32'(reject_o), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
